// File: rtl/multi_channel_synchronizer.sv
// Multi-channel single-bit CDC synchronizer with registered rise/fall pulses.
// Define SYNC_GLITCH_FILTER_EN to add per-channel stability filtering before level_out.
`timescale 1ns/1ps
module multi_channel_synchronizer #(
    parameter int NUM_CH     = 4,
    parameter int STAGES     = 2,
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = $clog2(FILTER_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] data_in,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] rise_out,
    output logic [NUM_CH-1:0] fall_out
);

    if (NUM_CH < 1 || STAGES < 2 || FILTER_LEN < 1 || CNT_W < $clog2(FILTER_LEN + 1)) begin : g_bad_param
        $error("multi_channel_synchronizer: illegal parameter combination");
    end

    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sync_q [STAGES];
    logic [NUM_CH-1:0] sync_last;
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_last = sync_q[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];

    // A channel only adopts sync_last after it has differed from level_q for FILTER_LEN cycles.
    always_comb begin
        level_d = level_q;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (sync_last[c] == level_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_W'(FILTER_LEN - 1)) begin
                level_d[c] = sync_last[c];
                cnt_d[c]   = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
        end
    end
`else
    always_comb begin
        level_d = sync_last;
    end
`endif

    // Pulses are registered with level_q so they land on the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// Directed bench for multi_channel_synchronizer; two instances (STAGES=2/FILTER_LEN=4 and
// STAGES=3/FILTER_LEN=8). Filter-dependent scenarios follow SYNC_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module tb_multi_channel_synchronizer;

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int LAT_A = 2 + 4;
    localparam int LAT_B = 3 + 8;
`else
    localparam int LAT_A = 2 + 1;
    localparam int LAT_B = 3 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] data_a = '0, data_b = '0;
    logic [3:0] lvl_a, rise_a, fall_a;
    logic [3:0] lvl_b, rise_b, fall_b;
    int         n_vec = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    multi_channel_synchronizer #(.NUM_CH(4), .STAGES(2), .FILTER_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a),
        .level_out(lvl_a), .rise_out(rise_a), .fall_out(fall_a)
    );

    multi_channel_synchronizer #(.NUM_CH(4), .STAGES(3), .FILTER_LEN(8)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b),
        .level_out(lvl_b), .rise_out(rise_b), .fall_out(fall_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e_lvl, e_rise;
        rst = 1'b1;
        data_a = 4'hF;
        data_b = 4'h0;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if ({lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b} !== 24'h0) begin
                n_miss++;
                $display("FAIL reset_hold cyc%0d: got a=%h/%h/%h b=%h/%h/%h want all 0",
                         k, lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= LAT_A + 1; k++) begin
            step();
            e_lvl  = (k >= LAT_A) ? 4'hF : 4'h0;
            e_rise = (k == LAT_A) ? 4'hF : 4'h0;
            n_vec++;
            if (lvl_a !== e_lvl || rise_a !== e_rise || fall_a !== 4'h0) begin
                n_miss++;
                $display("FAIL reset_release edge%0d: got lvl=%h rise=%h fall=%h want lvl=%h rise=%h fall=0",
                         k, lvl_a, rise_a, fall_a, e_lvl, e_rise);
            end
        end
    endtask

    task automatic test_single_step();
        logic [3:0] e_lvl, e_rise;
        data_b = 4'b0010;
        for (int k = 1; k <= LAT_B + 1; k++) begin
            step();
            e_lvl  = (k >= LAT_B) ? 4'b0010 : 4'b0000;
            e_rise = (k == LAT_B) ? 4'b0010 : 4'b0000;
            n_vec++;
            if (lvl_b !== e_lvl || rise_b !== e_rise || fall_b !== 4'h0) begin
                n_miss++;
                $display("FAIL single_step edge%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=0000",
                         k, lvl_b, rise_b, fall_b, e_lvl, e_rise);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e_lvl, e_rise, e_fall;
        data_a = 4'b0101;
        for (int k = 0; k < LAT_A + 2; k++) step();
        n_vec++;
        if (lvl_a !== 4'b0101 || rise_a !== 4'h0 || fall_a !== 4'h0) begin
            n_miss++;
            $display("FAIL simul_setup: got lvl=%b rise=%b fall=%b want 0101/0000/0000", lvl_a, rise_a, fall_a);
        end
        data_a = 4'b1010;
        for (int k = 1; k <= LAT_A + 1; k++) begin
            step();
            e_lvl  = (k >= LAT_A) ? 4'b1010 : 4'b0101;
            e_rise = (k == LAT_A) ? 4'b1010 : 4'b0000;
            e_fall = (k == LAT_A) ? 4'b0101 : 4'b0000;
            n_vec++;
            if (lvl_a !== e_lvl || rise_a !== e_rise || fall_a !== e_fall || (rise_a & fall_a) !== 4'h0) begin
                n_miss++;
                $display("FAIL simultaneous edge%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                         k, lvl_a, rise_a, fall_a, e_lvl, e_rise, e_fall);
            end
        end
        data_a = 4'h0;
        for (int k = 0; k < LAT_A + 2; k++) step();
        n_vec++;
        if (lvl_a !== 4'h0 || rise_a !== 4'h0 || fall_a !== 4'h0) begin
            n_miss++;
            $display("FAIL simul_clear: got lvl=%b rise=%b fall=%b want all 0", lvl_a, rise_a, fall_a);
        end
    endtask

`ifdef SYNC_GLITCH_FILTER_EN
    task automatic test_glitch_reject();
        data_a[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) data_a[0] = 1'b0;
            step();
            n_vec++;
            if (lvl_a !== 4'h0 || rise_a !== 4'h0 || fall_a !== 4'h0) begin
                n_miss++;
                $display("FAIL glitch3 edge%0d: got lvl=%b rise=%b fall=%b want all 0", k, lvl_a, rise_a, fall_a);
            end
        end
    endtask

    task automatic test_glitch_pass();
        logic e_lvl, e_rise, e_fall;
        data_a[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 5) data_a[0] = 1'b0;
            step();
            e_lvl  = (k >= 6 && k < 10);
            e_rise = (k == 6);
            e_fall = (k == 10);
            n_vec++;
            if (lvl_a !== {3'b0, e_lvl} || rise_a !== {3'b0, e_rise} || fall_a !== {3'b0, e_fall}) begin
                n_miss++;
                $display("FAIL glitch4 edge%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                         k, lvl_a, rise_a, fall_a, e_lvl, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        data_a[2] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (lvl_a !== 4'h0 || rise_a !== 4'h0) begin
            n_miss++;
            $display("FAIL rst_mid_hold: got lvl=%b rise=%b want 0000/0000", lvl_a, rise_a);
        end
        for (int k = 1; k <= LAT_A + 1; k++) begin
            step();
            n_vec++;
            if (lvl_a !== ((k >= LAT_A) ? 4'b0100 : 4'b0000) ||
                rise_a !== ((k == LAT_A) ? 4'b0100 : 4'b0000) || fall_a !== 4'h0) begin
                n_miss++;
                $display("FAIL rst_mid_release edge%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b",
                         k, lvl_a, rise_a, fall_a, (k >= LAT_A) ? 4'b0100 : 4'b0000,
                         (k == LAT_A) ? 4'b0100 : 4'b0000);
            end
        end
    endtask
`else
    task automatic test_no_filter_pulse();
        logic [3:0] e_lvl, e_rise, e_fall;
        data_b[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) data_b[0] = 1'b0;
            e_lvl  = (k == 4) ? 4'b0011 : 4'b0010;
            e_rise = (k == 4) ? 4'b0001 : 4'b0000;
            e_fall = (k == 5) ? 4'b0001 : 4'b0000;
            n_vec++;
            if (lvl_b !== e_lvl || rise_b !== e_rise || fall_b !== e_fall) begin
                n_miss++;
                $display("FAIL nofilter_pulse edge%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                         k, lvl_b, rise_b, fall_b, e_lvl, e_rise, e_fall);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_simultaneous();
`ifdef SYNC_GLITCH_FILTER_EN
        test_glitch_reject();
        test_glitch_pass();
        test_reset_mid_filter();
`else
        test_no_filter_pulse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multi_channel_synchronizer.md
# multi_channel_synchronizer

Multi-channel single-bit clock-domain-crossing synchronizer for the destination domain of the dual-clock FIFO and NoC control paths. Each channel runs through a configurable-depth flip-flop chain. An optional glitch filter then requires the synchronized value to be stable before the output changes. Registered rise and fall pulses accompany every output transition, so consumers get clean edge events without their own edge detectors.

## Interface
- NUM_CH, 4, number of independent 1-bit channels (>=1)
- STAGES, 2, synchronizer flip-flops per channel (>=2; use 3 for high-speed clocks)
- FILTER_LEN, 4, consecutive stable cycles required before level_out changes (>=1); used only with the filter compiled in
- CNT_W, $clog2(FILTER_LEN+1), filter counter width (derived; not overridden)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  destination clock
- rst  in  1  synchronous active-high reset
- data_in  in  NUM_CH  asynchronous inputs, one bit per channel
- level_out  out  NUM_CH  synchronized (and filtered) level
- rise_out  out  NUM_CH  one-cycle pulse on each 0->1 transition of level_out
- fall_out  out  NUM_CH  one-cycle pulse on each 1->0 transition of level_out

## Operation
- Per channel: shift chain sync[0..STAGES-1]. sync[0] <= data_in; sync[i+1] <= sync[i]. The chain carries the ASYNC_REG="TRUE" attribute. sync_last = sync[STAGES-1].
- Unfiltered decision: level_out <= sync_last every cycle.
- Filtered decision (per-channel counter cnt):
  - If sync_last == level_out: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: level_out <= sync_last and cnt <= 0.
  - Else: cnt <= cnt+1.
- Edge outputs are registered on the same edge that updates level_out:
  - rise_out <= next_level & ~level_out
  - fall_out <= ~next_level & level_out
  - Each pulse is exactly 1 cycle wide and coincides with the first cycle of the new level.
- Channels are fully independent. Any combination of channels may transition in the same cycle, and each channel pulses independently.
- Reset: every sync stage, level_out, rise_out, fall_out and cnt go to 0 on the next edge.
  - Reset mid-transition discards in-flight samples and the partial count.
  - After reset release, an input held at 1 produces a normal 0->1 transition with a rise_out pulse at the nominal latency.

## Timing
- Latency is measured from the first clk edge that samples the new data_in value into sync[0]. Edge 1 is that sampling edge.
- Unfiltered: level_out changes at edge STAGES+1.
- Filtered: level_out changes at edge STAGES+FILTER_LEN. With FILTER_LEN=1 this equals the unfiltered latency.
- Glitch rejection: a pulse at sync_last shorter than FILTER_LEN cycles never reaches level_out. The counter clears on the first cycle sync_last matches level_out again.
- Minimum event spacing:
  - Input toggles closer than STAGES+1 cycles (unfiltered) may merge.
  - Input toggles closer than FILTER_LEN cycles (filtered) may merge.
  - When toggles merge, at most one rise or fall pulse is produced per level_out change, and rise_out and fall_out are never both high on one channel.
- Counter arithmetic: cnt never exceeds FILTER_LEN-1 and never wraps.

## Configuration
- Macro: SYNC_GLITCH_FILTER_EN.
- Defined: per-channel filter counters are instantiated and the filtered rules and latency apply.
- Undefined: no counters are built and FILTER_LEN is ignored. level_out is registered sync_last, with latency STAGES+1. The output register is kept so the edge pulses remain aligned.

## Test plan
- Reset check: rst high for 3 cycles with data_in=4'hF -> all outputs 0 during reset. After release (STAGES=2, filter off), level_out=4'hF at edge 3 with a 1-cycle rise_out=4'hF.
- Single-channel step, STAGES=3, filter off: data_in[1] 0->1 -> level_out[1] rises at edge 4 with rise_out[1] high for that one cycle. Other channels stay 0.
- Glitch rejection, STAGES=2, FILTER_LEN=4, filter on: a 3-cycle high pulse on data_in[0] -> level_out[0] stays 0 and no pulses occur. A 4-cycle pulse -> level_out[0] rises at edge 6, then falls later with a 1-cycle fall_out.
- Simultaneous events: data_in 4'b0101 -> 4'b1010 in one cycle -> rise_out=4'b1010 and fall_out=4'b0101 in the same cycle. Never rise and fall on the same bit.
- Reset mid-filter: assert rst when cnt[2]=2 -> cnt is cleared. After release with the input still high, level_out[2] rises a full STAGES+FILTER_LEN edges after release.
- Macro off, FILTER_LEN=8: 1-cycle input pulse held through the chain -> level_out follows at STAGES+1 latency with no filtering.
